// File: rtl/dram_controller.sv
// Single-bank DRAM controller for a 68000 bus: turns AS + address into RAS/CAS/OE strobes
// with multiplexed row/column address, returns DTACK, and runs periodic CAS-before-RAS refresh.
module dram_controller #(
  parameter int REFRESH_INTERVAL = 120,
  parameter int PRECHARGE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        AS,
  input  logic [23:0] ADDR_IN,
  output logic [10:0] ADDR_OUT,
  output logic        RAS,
  output logic        CAS,
  output logic        OE,
  output logic        DTACK_DRAM
);

  localparam int REF_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int PH_W  = (PRECHARGE_CYCLES > 2) ? $clog2(PRECHARGE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_HOLD,
    S_PRE,
    S_REF_CAS,
    S_REF_RAS
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic              pend_q, pend_d;
  logic [10:0]       col_q, col_d;
  logic [10:0]       addr_q, addr_d;
  logic              ras_q, ras_d;
  logic              cas_q, cas_d;
  logic              oe_q, oe_d;
  logic              dtack_q, dtack_d;
  logic              selected;
  logic              expire;
  logic              unused_addr_bit;

  assign unused_addr_bit = ADDR_IN[0];
  assign selected        = !AS && !ADDR_IN[23];
  assign expire          = (ref_cnt_q == REF_W'(REFRESH_INTERVAL - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_REF_CAS;
        end else if (selected) begin
          state_d = S_ROW;
          col_d   = ADDR_IN[11:1];
        end
      end
      S_ROW:     state_d = S_COL;
      S_COL:     state_d = S_HOLD;
      S_HOLD:    if (AS) state_d = S_PRE;
      S_PRE:     if (phase_q == PH_W'(PRECHARGE_CYCLES - 1)) state_d = S_IDLE;
      S_REF_CAS: state_d = S_REF_RAS;
      S_REF_RAS: if (phase_q == PH_W'(1)) state_d = S_PRE;
      default:   state_d = S_IDLE;
    endcase

    // Phase counts clocks spent in the current state; restarts on every transition.
    phase_d = (state_d != state_q) ? '0 : phase_q + 1'b1;

    ref_cnt_d = expire ? '0 : ref_cnt_q + 1'b1;
    // Entering refresh consumes the request, even if the timer expires on the same edge.
    pend_d    = (state_q == S_IDLE && state_d == S_REF_CAS) ? 1'b0 : (pend_q | expire);

    // Outputs are registered from the next state so strobes line up with state entry.
    ras_d   = 1'b1;
    cas_d   = 1'b1;
    oe_d    = 1'b1;
    dtack_d = 1'b1;
    addr_d  = addr_q;
    case (state_d)
      S_IDLE: addr_d = ADDR_IN[22:12];
      S_ROW: begin
        ras_d  = 1'b0;
        addr_d = ADDR_IN[22:12];
      end
      S_COL, S_HOLD: begin
        ras_d   = 1'b0;
        cas_d   = 1'b0;
        oe_d    = 1'b0;
        dtack_d = 1'b0;
        addr_d  = col_d;
      end
      S_REF_CAS: cas_d = 1'b0;
      S_REF_RAS: begin
        cas_d = 1'b0;
        ras_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      ref_cnt_q <= '0;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      ras_q     <= 1'b1;
      cas_q     <= 1'b1;
      oe_q      <= 1'b1;
      dtack_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ref_cnt_q <= ref_cnt_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      ras_q     <= ras_d;
      cas_q     <= cas_d;
      oe_q      <= oe_d;
      dtack_q   <= dtack_d;
    end
  end

  always_ff @(posedge CLK) begin
    col_q <= col_d;
  end

  assign ADDR_OUT   = addr_q;
  assign RAS        = ras_q;
  assign CAS        = cas_q;
  assign OE         = oe_q;
  assign DTACK_DRAM = dtack_q;

endmodule

// File: tb/tb_dram_controller.sv
// Randomized scoreboard bench for dram_controller: a transaction-script reference model
// predicts the strobe/address vector after every edge; a negedge monitor compares.
module tb_dram_controller;

  localparam int RI = 120;
  localparam int PC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_n;
  logic [23:0] addr_in;
  logic [10:0] addr_out;
  logic        ras, cas, oe, dtack;

  always #5 clk = ~clk;

  dram_controller #(.REFRESH_INTERVAL(RI), .PRECHARGE_CYCLES(PC)) dut (
    .CLK(clk), .RST(rst), .AS(as_n), .ADDR_IN(addr_in),
    .ADDR_OUT(addr_out), .RAS(ras), .CAS(cas), .OE(oe), .DTACK_DRAM(dtack)
  );

  typedef struct packed {
    logic [10:0] a;
    logic        ras;
    logic        cas;
    logic        oe;
    logic        dtack;
  } vec_t;

  typedef enum int {K_ROW, K_COL, K_REFC, K_REFR, K_PRE, K_IDLE} kind_e;

  vec_t  exp_q[$];
  kind_e script[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ref_seen = 0;
  int    act_seen = 0;

  bit          hold_mode;
  bit          pending;
  int          tmr;
  logic [10:0] m_addr;
  logic [10:0] m_col;

  // Reference model: each bus operation is a script of output phases, one per clock.
  task automatic model_step();
    vec_t  v;
    kind_e k;
    bit    enter_ref;
    bit    expire;
    enter_ref = 1'b0;
    v = '{a: 11'd0, ras: 1'b1, cas: 1'b1, oe: 1'b1, dtack: 1'b1};
    if (rst) begin
      script.delete();
      hold_mode = 1'b0;
      pending   = 1'b0;
      tmr       = 0;
      m_addr    = '0;
    end else begin
      if (hold_mode) begin
        hold_mode = 1'b0;
        if (as_n) begin
          repeat (PC) script.push_back(K_PRE);
          script.push_back(K_IDLE);
        end else begin
          script.push_back(K_COL);
        end
      end else if (script.size() == 0) begin
        if (pending) begin
          enter_ref = 1'b1;
          script.push_back(K_REFC);
          script.push_back(K_REFR);
          script.push_back(K_REFR);
          repeat (PC) script.push_back(K_PRE);
          script.push_back(K_IDLE);
        end else if (!as_n && !addr_in[23]) begin
          m_col = addr_in[11:1];
          script.push_back(K_ROW);
          script.push_back(K_COL);
          script.push_back(K_COL);
        end else begin
          script.push_back(K_IDLE);
        end
      end
      k = script.pop_front();
      case (k)
        K_ROW:  begin m_addr = addr_in[22:12]; v.ras = 1'b0; end
        K_COL:  begin m_addr = m_col; v.ras = 1'b0; v.cas = 1'b0; v.oe = 1'b0; v.dtack = 1'b0; end
        K_REFC: v.cas = 1'b0;
        K_REFR: begin v.cas = 1'b0; v.ras = 1'b0; end
        K_IDLE: m_addr = addr_in[22:12];
        default: ;
      endcase
      v.a = m_addr;
      if (k == K_COL && script.size() == 0) hold_mode = 1'b1;
      expire  = (tmr == RI - 1);
      tmr     = expire ? 0 : tmr + 1;
      pending = enter_ref ? 1'b0 : (pending | expire);
    end
    exp_q.push_back(v);
  endtask

  task automatic cycle(input logic r, input logic a, input logic [23:0] ad);
    rst = r;
    as_n = a;
    addr_in = ad;
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    vec_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({addr_out, ras, cas, oe, dtack} !== e) begin
        errors++;
        $display("FAIL out @cyc %0d: got addr=%h ras=%b cas=%b oe=%b dtack=%b, exp addr=%h ras=%b cas=%b oe=%b dtack=%b",
                 cyc, addr_out, ras, cas, oe, dtack, e.a, e.ras, e.cas, e.oe, e.dtack);
      end
      if (ras && !cas) ref_seen++;
      if (!ras || !cas || !oe || !dtack) act_seen++;
    end
  end

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, exp %0d", name, got, want);
    end
  endtask

  initial begin
    int          snap;
    int          n;
    logic [23:0] ra;

    // Reset held three clocks
    repeat (3) cycle(1'b1, 1'b1, 24'h0);

    // Read at 0x120034, AS low 30 clocks, then release
    repeat (30) cycle(1'b0, 1'b0, 24'h120034);
    repeat (4) cycle(1'b0, 1'b1, 24'h120034);

    // Upper 8 MB: no activity at all
    repeat (2) cycle(1'b0, 1'b1, 24'h900000);
    @(negedge clk); #1;
    snap = act_seen;
    repeat (20) cycle(1'b0, 1'b0, 24'h900000);
    repeat (2) cycle(1'b0, 1'b1, 24'h900000);
    @(negedge clk); #1;
    check_int("deselected_activity", act_seen - snap, 0);

    // Idle 3 refresh intervals after reset -> exactly three refreshes
    cycle(1'b1, 1'b1, 24'h0);
    @(negedge clk); #1;
    snap = ref_seen;
    repeat (3 * RI + 6) cycle(1'b0, 1'b1, 24'h0);
    @(negedge clk); #1;
    check_int("idle_refresh_count", ref_seen - snap, 3);

    // AS arriving in the same clock a refresh starts
    n = 0;
    while (!(pending && script.size() == 0 && !hold_mode) && n < 300) begin
      cycle(1'b0, 1'b1, 24'h0);
      n++;
    end
    check_int("refresh_wait_bounded", (n < 300) ? 1 : 0, 1);
    repeat (14) cycle(1'b0, 1'b0, 24'h0ABCDE);
    repeat (4) cycle(1'b0, 1'b1, 24'h0ABCDE);

    // Reset pulsed during HOLD
    repeat (8) cycle(1'b0, 1'b0, 24'h3456AA);
    cycle(1'b1, 1'b0, 24'h3456AA);
    repeat (5) cycle(1'b0, 1'b0, 24'h3456AA);
    repeat (4) cycle(1'b0, 1'b1, 24'h3456AA);

    // Random bus traffic
    for (int t = 0; t < 300; t++) begin
      ra = {($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 23'($urandom)};
      repeat ($urandom_range(0, 5)) cycle(1'b0, 1'b1, 24'($urandom));
      n = $urandom_range(2, 12);
      for (int i = 0; i < n; i++) begin
        cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 1'b0, ra);
      end
      cycle(1'b0, 1'b1, ra);
    end

    repeat (4) cycle(1'b0, 1'b1, 24'h0);
    @(negedge clk); #1;
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
